// File: rtl/pop_arbiter_pkg.sv
// rtl/pop_arbiter_pkg.sv - shared constants, state encoding and index helper for pop_arbiter
package pop_arbiter_pkg;

    localparam int N_FIFOS = 5;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    // Pointer starts on the last FIFO so the first search begins at index 0.
    localparam logic [IDX_W-1:0] RR_RST = 3'd4;

    // (base + k) mod N_FIFOS for base in 0..4 and k in 1..5.
    function automatic logic [IDX_W-1:0] rr_offset(input logic [IDX_W-1:0] base,
                                                   input int unsigned       k);
        logic [3:0] s;
        s = {1'b0, base} + 4'(k);
        if (s >= 4'(N_FIFOS)) begin
            s = s - 4'(N_FIFOS);
        end
        return s[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/pop_arbiter_if.sv
// rtl/pop_arbiter_if.sv - FIFO-side and downstream-side signal bundle of pop_arbiter
// Signals:
//   fifo_empty, fifo_data_0..4, dest_almost_full, enable : towards the arbiter
//   pop_0..4, data_out, valid_out, idle                  : from the arbiter
// Modports: slave = arbiter view, master = environment view.
interface pop_arbiter_if #(
    parameter int DATA_W = 6
);
    import pop_arbiter_pkg::*;

    logic [N_FIFOS-1:0] fifo_empty;
    logic [DATA_W-1:0]  fifo_data_0;
    logic [DATA_W-1:0]  fifo_data_1;
    logic [DATA_W-1:0]  fifo_data_2;
    logic [DATA_W-1:0]  fifo_data_3;
    logic [DATA_W-1:0]  fifo_data_4;
    logic               dest_almost_full;
    logic               enable;
    logic               pop_0;
    logic               pop_1;
    logic               pop_2;
    logic               pop_3;
    logic               pop_4;
    logic [DATA_W-1:0]  data_out;
    logic               valid_out;
    logic               idle;

    modport slave (
        input  fifo_empty, fifo_data_0, fifo_data_1, fifo_data_2, fifo_data_3, fifo_data_4,
        input  dest_almost_full, enable,
        output pop_0, pop_1, pop_2, pop_3, pop_4, data_out, valid_out, idle
    );

    modport master (
        output fifo_empty, fifo_data_0, fifo_data_1, fifo_data_2, fifo_data_3, fifo_data_4,
        output dest_almost_full, enable,
        input  pop_0, pop_1, pop_2, pop_3, pop_4, data_out, valid_out, idle
    );

endinterface

// File: rtl/pop_arbiter_rr_picker.sv
// rtl/pop_arbiter_rr_picker.sv - combinational round-robin search over five requests
// Ports:
//   i_req       in  5  request per FIFO (1 = non-empty)
//   i_rr_ptr    in  3  index granted last; search starts one past it
//   o_grant     out 5  one-hot grant
//   o_grant_idx out 3  index of the granted request
//   o_any_grant out 1  some request was found
module rr_picker
    import pop_arbiter_pkg::*;
(
    input  logic [N_FIFOS-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [N_FIFOS-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any_grant
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        w_idx       = '0;
        // Offsets 1..5 visit every FIFO once, the last-granted one last.
        for (int k = 1; k <= N_FIFOS; k++) begin
            w_idx = rr_offset(i_rr_ptr, k);
            if (!o_any_grant && i_req[w_idx]) begin
                o_any_grant    = 1'b1;
                o_grant_idx    = w_idx;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pop_arbiter.sv
// rtl/pop_arbiter.sv - round-robin pop arbiter over five registered-read FIFOs
// Ports:
//   clk     in  1  clock, posedge
//   reset_L in  1  asynchronous active-low reset
//   bus     slave  fifo_empty/fifo_data_0..4/dest_almost_full/enable in,
//                  pop_0..4/data_out/valid_out/idle out
module pop_arbiter
    import pop_arbiter_pkg::*;
#(
    parameter int DATA_W = 6
) (
    input  logic          clk,
    input  logic          reset_L,
    pop_arbiter_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_pend_sel;
    logic               r_pend_v;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_valid_out;

    logic [N_FIFOS-1:0] w_req;
    logic [N_FIFOS-1:0] w_pick;
    logic [N_FIFOS-1:0] w_pop;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_pick_any;
    logic               w_grant_en;
    logic               w_grant;
    logic               w_all_empty;
    logic [DATA_W-1:0]  w_rd_data;

    assign w_req       = ~bus.fifo_empty;
    assign w_all_empty = &bus.fifo_empty;

    rr_picker u_picker (
        .i_req       (w_req),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_pick),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_pick_any)
    );

    // Pops come straight from registered state, so an asynchronous reset
    // (state -> IDLE) removes them within the same cycle.
    assign w_grant_en = (r_state == ACTIVE) && bus.enable && !bus.dest_almost_full;
    assign w_pop      = w_grant_en ? w_pick : '0;
    assign w_grant    = w_grant_en && w_pick_any;

    assign bus.pop_0 = w_pop[0];
    assign bus.pop_1 = w_pop[1];
    assign bus.pop_2 = w_pop[2];
    assign bus.pop_3 = w_pop[3];
    assign bus.pop_4 = w_pop[4];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.enable && !w_all_empty) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (bus.dest_almost_full || !bus.enable) begin
                    w_state_nxt = STALL;
                end else if (w_all_empty && !r_pend_v) begin
                    w_state_nxt = IDLE;
                end
            end
            STALL: begin
                if (!bus.dest_almost_full && bus.enable) begin
                    w_state_nxt = ACTIVE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FIFO read data is valid the cycle after its pop, i.e. while r_pend_v is set.
    always_comb begin
        w_rd_data = '0;
        case (r_pend_sel)
            3'd0:    w_rd_data = bus.fifo_data_0;
            3'd1:    w_rd_data = bus.fifo_data_1;
            3'd2:    w_rd_data = bus.fifo_data_2;
            3'd3:    w_rd_data = bus.fifo_data_3;
            3'd4:    w_rd_data = bus.fifo_data_4;
            default: w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= IDLE;
            r_rr_ptr    <= RR_RST;
            r_pend_v    <= 1'b0;
            r_pend_sel  <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pend_v <= w_grant;
            if (w_grant) begin
                r_rr_ptr   <= w_grant_idx;
                r_pend_sel <= w_grant_idx;
            end
            r_valid_out <= r_pend_v;
            if (r_pend_v) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.idle      = (r_state == IDLE) && !r_pend_v && !r_valid_out;

endmodule
